// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
// Build option DM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
package dm_arb_pkg;

    localparam int NUM_REQ    = 2;
    localparam int DEFAULT_AW = 8;
    localparam int DEFAULT_DW = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] owner_onehot(input logic idx);
        owner_onehot = idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dm_arb_arb2.sv
// Two-way arbitration decision for dm_arb.
// DM_ARB_ROUND_ROBIN_EN defined: ties go to the requester that did not win last; otherwise requester 0 wins ties.
module arb2
    import dm_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
`ifdef DM_ARB_ROUND_ROBIN_EN
    input  logic               last_grant,
`endif
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
`ifdef DM_ARB_ROUND_ROBIN_EN
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
`else
            2'b11:   grant = 2'b01;
`endif
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/dm_arb.sv
// Two-requester arbiter in front of a single-port data memory: grant, one access cycle, read response.
// DM_ARB_ROUND_ROBIN_EN enables round-robin tie breaking (fixed priority to requester 0 otherwise).
module dm_arb
    import dm_arb_pkg::*;
#(
    parameter int AW = DEFAULT_AW,
    parameter int DW = DEFAULT_DW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] we,
    input  logic [AW-1:0]      addr0,
    input  logic [AW-1:0]      addr1,
    input  logic [DW-1:0]      wdata0,
    input  logic [DW-1:0]      wdata1,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] rvalid,
    output logic [DW-1:0]      rdata,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    output logic               mem_wr_en,
    input  logic [DW-1:0]      mem_rdata
);

    state_t               state;
    logic                 lat_we;
    logic                 owner;
    logic [NUM_REQ-1:0]   arb_grant;
    logic                 win;
`ifdef DM_ARB_ROUND_ROBIN_EN
    logic                 last_grant;
`endif

    arb2 u_arb2 (
        .req        (req),
`ifdef DM_ARB_ROUND_ROBIN_EN
        .last_grant (last_grant),
`endif
        .grant      (arb_grant)
    );

    assign win = arb_grant[1];

    // Grant is combinational so the requester sees it in the cycle it is accepted; suppressed while reset is held.
    assign gnt       = (state == IDLE && rst_n) ? arb_grant : '0;
    assign mem_wr_en = (state == ACCESS) && lat_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_we     <= 1'b0;
            owner      <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
            rvalid     <= '0;
`ifdef DM_ARB_ROUND_ROBIN_EN
            last_grant <= 1'b1;
`endif
        end else begin
            rvalid <= '0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state     <= ACCESS;
                        owner     <= win;
                        lat_we    <= we[win];
                        mem_addr  <= win ? addr1 : addr0;
                        mem_wdata <= win ? wdata1 : wdata0;
`ifdef DM_ARB_ROUND_ROBIN_EN
                        last_grant <= win;
`endif
                    end
                end
                ACCESS: begin
                    state <= IDLE;
                    // Reads return one cycle later; writes leave rdata untouched.
                    if (!lat_we) begin
                        rdata  <= mem_rdata;
                        rvalid <= owner_onehot(owner);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_arb.sv
// Self-checking bench for dm_arb with a behavioural 256x8 memory and a transaction-level reference model.
// Honours DM_ARB_ROUND_ROBIN_EN the same way as the design.
module tb_dm_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req, we;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic [1:0] gnt, rvalid;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic       mem_wr_en;

    int total = 0;
    int bad   = 0;

    logic [7:0] seed_mem  [256];
    logic [7:0] bench_mem [256];
    logic       mem_loaded = 1'b0;

    // Reference model state: a grant may only happen once two cycles have passed since the previous one.
    logic [7:0] ref_mem [256];
    int         since;
    int         winner;
    logic       p_we, p_owner;
    logic [7:0] p_addr, p_data;
    logic [1:0] exp_gnt, exp_rvalid;
    logic [7:0] exp_rdata, exp_addr, exp_wdata;
    logic       exp_wr_en;
`ifdef DM_ARB_ROUND_ROBIN_EN
    logic       ref_last;
`endif

    always #5 clk = ~clk;

    assign mem_rdata = bench_mem[mem_addr];

    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) bench_mem[i] <= seed_mem[i];
            mem_loaded <= 1'b1;
        end else if (mem_wr_en) begin
            bench_mem[mem_addr] <= mem_wdata;
        end
    end

    dm_arb #(.AW(8), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wr_en (mem_wr_en),
        .mem_rdata (mem_rdata)
    );

    always @(negedge clk) begin
        total++;
        if (!$onehot0(gnt) || !$onehot0(rvalid)) begin
            bad++;
            $display("[TB] FAIL onehot: gnt=%b rvalid=%b required one-hot or zero", gnt, rvalid);
        end
    end

    task automatic drive(input logic [1:0] r, input logic [1:0] w, input logic [7:0] a0,
                         input logic [7:0] a1, input logic [7:0] d0, input logic [7:0] d1);
        req = r; we = w; addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    endtask

    // Compute what this cycle should show, then move to the sampling point.
    task automatic sample();
        exp_gnt = 2'b00;
        if (rst_n && since >= 2 && req != 2'b00) begin
            if (req == 2'b01)      winner = 0;
            else if (req == 2'b10) winner = 1;
            else begin
`ifdef DM_ARB_ROUND_ROBIN_EN
                winner = ref_last ? 0 : 1;
`else
                winner = 0;
`endif
            end
            exp_gnt = (winner == 0) ? 2'b01 : 2'b10;
        end
        exp_wr_en = rst_n && since == 1 && p_we;
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst_n) begin
            since = 2; exp_rvalid = 0; exp_rdata = 0; exp_addr = 0; exp_wdata = 0;
            p_we = 0; p_owner = 0;
`ifdef DM_ARB_ROUND_ROBIN_EN
            ref_last = 1'b1;
`endif
        end else begin
            exp_rvalid = 2'b00;
            if (since == 1) begin
                if (p_we) ref_mem[p_addr] = p_data;
                else begin
                    exp_rvalid = p_owner ? 2'b10 : 2'b01;
                    exp_rdata  = ref_mem[p_addr];
                end
            end
            if (exp_gnt != 2'b00) begin
                p_owner   = (winner == 1);
                p_we      = we[winner];
                p_addr    = (winner == 1) ? addr1 : addr0;
                p_data    = (winner == 1) ? wdata1 : wdata0;
                exp_addr  = p_addr;
                exp_wdata = p_data;
                since     = 1;
`ifdef DM_ARB_ROUND_ROBIN_EN
                ref_last  = (winner == 1);
`endif
            end else if (since < 2) begin
                since++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(2'b11, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00);
        advance(); advance();
        sample();
        total += 6;
        if (gnt !== 2'b00)       begin bad++; $display("[TB] FAIL rst_gnt: got %b want 00", gnt); end
        if (rvalid !== 2'b00)    begin bad++; $display("[TB] FAIL rst_rvalid: got %b want 00", rvalid); end
        if (rdata !== 8'h00)     begin bad++; $display("[TB] FAIL rst_rdata: got %h want 00", rdata); end
        if (mem_addr !== 8'h00)  begin bad++; $display("[TB] FAIL rst_addr: got %h want 00", mem_addr); end
        if (mem_wdata !== 8'h00) begin bad++; $display("[TB] FAIL rst_wdata: got %h want 00", mem_wdata); end
        if (mem_wr_en !== 1'b0)  begin bad++; $display("[TB] FAIL rst_wr_en: got %b want 0", mem_wr_en); end
        advance();
        rst_n = 1'b1;
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic test_write_read();
        drive(2'b01, 2'b01, 8'h10, 8'h00, 8'hA5, 8'h00);
        sample();
        total += 2;
        if (gnt !== 2'b01)      begin bad++; $display("[TB] FAIL wr_gnt: got %b want 01", gnt); end
        if (mem_wr_en !== 1'b0) begin bad++; $display("[TB] FAIL wr_en_T: got %b want 0", mem_wr_en); end
        advance();
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        sample();
        total += 4;
        if (mem_wr_en !== 1'b1)  begin bad++; $display("[TB] FAIL wr_en_T1: got %b want 1", mem_wr_en); end
        if (mem_addr !== 8'h10)  begin bad++; $display("[TB] FAIL wr_addr: got %h want 10", mem_addr); end
        if (mem_wdata !== 8'hA5) begin bad++; $display("[TB] FAIL wr_data: got %h want a5", mem_wdata); end
        if (gnt !== 2'b00)       begin bad++; $display("[TB] FAIL wr_gnt_access: got %b want 00", gnt); end
        advance();
        drive(2'b01, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00);
        sample();
        total += 3;
        if (gnt !== 2'b01)      begin bad++; $display("[TB] FAIL rd_gnt: got %b want 01", gnt); end
        if (mem_wr_en !== 1'b0) begin bad++; $display("[TB] FAIL wr_en_T2: got %b want 0", mem_wr_en); end
        if (rvalid !== 2'b00)   begin bad++; $display("[TB] FAIL wr_rvalid: got %b want 00", rvalid); end
        advance();
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        sample();
        total++;
        if (mem_wr_en !== 1'b0) begin bad++; $display("[TB] FAIL rd_wr_en: got %b want 0", mem_wr_en); end
        advance();
        sample();
        total += 2;
        if (rvalid !== 2'b01) begin bad++; $display("[TB] FAIL rd_rvalid: got %b want 01", rvalid); end
        if (rdata !== 8'hA5)  begin bad++; $display("[TB] FAIL rd_data: got %h want a5", rdata); end
        advance();
    endtask

    task automatic test_tie();
        logic [1:0] want;
        int         ngrant;
        rst_n = 1'b0;
        sample(); advance();
        rst_n = 1'b1;
        ngrant = 0;
        drive(2'b11, 2'b00, 8'h30, 8'h40, 8'h00, 8'h00);
        for (int c = 0; c < 8; c++) begin
            sample();
            if (c % 2 != 0) want = 2'b00;
`ifdef DM_ARB_ROUND_ROBIN_EN
            else want = ((c / 2) % 2 == 0) ? 2'b01 : 2'b10;
`else
            else want = 2'b01;
`endif
            total += 2;
            if (gnt !== want)         begin bad++; $display("[TB] FAIL tie_gnt c%0d: got %b want %b", c, gnt, want); end
            if (rvalid !== exp_rvalid) begin bad++; $display("[TB] FAIL tie_rvalid c%0d: got %b want %b", c, rvalid, exp_rvalid); end
            if (gnt != 2'b00) ngrant++;
            advance();
        end
        total++;
        if (ngrant != 4) begin bad++; $display("[TB] FAIL tie_count: got %0d want 4", ngrant); end
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        for (int c = 0; c < 2; c++) begin
            sample();
            total += 2;
            if (rvalid !== exp_rvalid) begin bad++; $display("[TB] FAIL tie_drain_rvalid: got %b want %b", rvalid, exp_rvalid); end
            if (rdata !== exp_rdata)   begin bad++; $display("[TB] FAIL tie_drain_rdata: got %h want %h", rdata, exp_rdata); end
            advance();
        end
    endtask

    task automatic test_cross();
        drive(2'b10, 2'b10, 8'h00, 8'hFF, 8'h00, 8'h3C);
        sample();
        total++;
        if (gnt !== 2'b10) begin bad++; $display("[TB] FAIL x_wr_gnt: got %b want 10", gnt); end
        advance();
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        sample();
        total += 3;
        if (mem_wr_en !== 1'b1)  begin bad++; $display("[TB] FAIL x_wr_en: got %b want 1", mem_wr_en); end
        if (mem_addr !== 8'hFF)  begin bad++; $display("[TB] FAIL x_wr_addr: got %h want ff", mem_addr); end
        if (mem_wdata !== 8'h3C) begin bad++; $display("[TB] FAIL x_wr_data: got %h want 3c", mem_wdata); end
        advance();
        drive(2'b01, 2'b00, 8'hFF, 8'h00, 8'h00, 8'h00);
        sample();
        total += 2;
        if (gnt !== 2'b01)    begin bad++; $display("[TB] FAIL x_rd_gnt: got %b want 01", gnt); end
        if (rvalid !== 2'b00) begin bad++; $display("[TB] FAIL x_wr_rvalid: got %b want 00", rvalid); end
        advance();
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        sample(); advance();
        sample();
        total += 2;
        if (rvalid !== 2'b01) begin bad++; $display("[TB] FAIL x_rd_rvalid: got %b want 01", rvalid); end
        if (rdata !== 8'h3C)  begin bad++; $display("[TB] FAIL x_rd_data: got %h want 3c", rdata); end
        advance();
    endtask

    task automatic test_reset_abort();
        logic [7:0] old;
        old = ref_mem[8'h20];
        drive(2'b01, 2'b01, 8'h20, 8'h00, 8'h77, 8'h00);
        sample();
        total++;
        if (gnt !== 2'b01) begin bad++; $display("[TB] FAIL ab_gnt: got %b want 01", gnt); end
        advance();
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        sample();
        total++;
        if (mem_wr_en !== 1'b1) begin bad++; $display("[TB] FAIL ab_wr_en_pre: got %b want 1", mem_wr_en); end
        rst_n = 1'b0;
        #1;
        total += 6;
        if (mem_wr_en !== 1'b0)  begin bad++; $display("[TB] FAIL ab_wr_en: got %b want 0", mem_wr_en); end
        if (gnt !== 2'b00)       begin bad++; $display("[TB] FAIL ab_gnt_rst: got %b want 00", gnt); end
        if (rvalid !== 2'b00)    begin bad++; $display("[TB] FAIL ab_rvalid: got %b want 00", rvalid); end
        if (rdata !== 8'h00)     begin bad++; $display("[TB] FAIL ab_rdata: got %h want 00", rdata); end
        if (mem_addr !== 8'h00)  begin bad++; $display("[TB] FAIL ab_addr: got %h want 00", mem_addr); end
        if (mem_wdata !== 8'h00) begin bad++; $display("[TB] FAIL ab_wdata: got %h want 00", mem_wdata); end
        advance();
        rst_n = 1'b1;
        drive(2'b01, 2'b00, 8'h20, 8'h00, 8'h00, 8'h00);
        sample();
        total++;
        if (gnt !== 2'b01) begin bad++; $display("[TB] FAIL ab_rd_gnt: got %b want 01", gnt); end
        advance();
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        sample(); advance();
        sample();
        total += 2;
        if (rvalid !== 2'b01) begin bad++; $display("[TB] FAIL ab_rd_rvalid: got %b want 01", rvalid); end
        if (rdata !== old)    begin bad++; $display("[TB] FAIL ab_rd_data: got %h want %h", rdata, old); end
        advance();
    endtask

    task automatic test_idle_noise();
        drive(2'b00, 2'b11, 8'h55, 8'h66, 8'h11, 8'h22);
        for (int c = 0; c < 3; c++) begin
            sample();
            total += 2;
            if (gnt !== 2'b00)      begin bad++; $display("[TB] FAIL idle_gnt: got %b want 00", gnt); end
            if (mem_wr_en !== 1'b0) begin bad++; $display("[TB] FAIL idle_wr_en: got %b want 0", mem_wr_en); end
            advance();
        end
        drive(2'b01, 2'b00, 8'h50, 8'h00, 8'h00, 8'h00);
        sample();
        total++;
        if (gnt !== 2'b01) begin bad++; $display("[TB] FAIL noise_gnt: got %b want 01", gnt); end
        advance();
        drive(2'b10, 2'b10, 8'h00, 8'h60, 8'h00, 8'h99);
        sample();
        total += 2;
        if (gnt !== 2'b00)      begin bad++; $display("[TB] FAIL noise_access_gnt: got %b want 00", gnt); end
        if (mem_wr_en !== 1'b0) begin bad++; $display("[TB] FAIL noise_wr_en: got %b want 0", mem_wr_en); end
        advance();
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        sample();
        total += 3;
        if (gnt !== 2'b00)       begin bad++; $display("[TB] FAIL noise_idle_gnt: got %b want 00", gnt); end
        if (rvalid !== 2'b01)    begin bad++; $display("[TB] FAIL noise_rvalid: got %b want 01", rvalid); end
        if (rdata !== exp_rdata) begin bad++; $display("[TB] FAIL noise_rdata: got %h want %h", rdata, exp_rdata); end
        advance();
    endtask

    task automatic test_random();
        logic [1:0] waiting;
        waiting = 2'b00;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!waiting[i]) begin
                    req[i] = ($urandom_range(0, 2) != 0);
                    we[i]  = $urandom_range(0, 1) != 0;
                    if (i == 0) begin addr0 = 8'($urandom_range(0, 15)); wdata0 = 8'($urandom); end
                    else        begin addr1 = 8'($urandom_range(0, 15)); wdata1 = 8'($urandom); end
                end
            end
            sample();
            total += 6;
            if (gnt !== exp_gnt)       begin bad++; $display("[TB] FAIL rnd_gnt c%0d: got %b want %b", c, gnt, exp_gnt); end
            if (rvalid !== exp_rvalid) begin bad++; $display("[TB] FAIL rnd_rvalid c%0d: got %b want %b", c, rvalid, exp_rvalid); end
            if (rdata !== exp_rdata)   begin bad++; $display("[TB] FAIL rnd_rdata c%0d: got %h want %h", c, rdata, exp_rdata); end
            if (mem_wr_en !== exp_wr_en) begin bad++; $display("[TB] FAIL rnd_wr_en c%0d: got %b want %b", c, mem_wr_en, exp_wr_en); end
            if (mem_addr !== exp_addr) begin bad++; $display("[TB] FAIL rnd_addr c%0d: got %h want %h", c, mem_addr, exp_addr); end
            if (mem_wdata !== exp_wdata) begin bad++; $display("[TB] FAIL rnd_wdata c%0d: got %h want %h", c, mem_wdata, exp_wdata); end
            waiting = req & ~exp_gnt;
            advance();
        end
        drive(2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
        sample(); advance();
        sample(); advance();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            seed_mem[i] = 8'($urandom);
            ref_mem[i]  = seed_mem[i];
        end
        seed_mem[8'h20] = 8'h5A;
        ref_mem[8'h20]  = 8'h5A;
        since = 2; winner = 0;
        p_we = 0; p_owner = 0; p_addr = 0; p_data = 0;
        exp_gnt = 0; exp_rvalid = 0; exp_rdata = 0; exp_addr = 0; exp_wdata = 0; exp_wr_en = 0;
`ifdef DM_ARB_ROUND_ROBIN_EN
        ref_last = 1'b1;
`endif
        $display("[TB] starting dm_arb bench");
        test_reset();
        test_write_read();
        test_tie();
        test_cross();
        test_reset_abort();
        test_idle_noise();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
